// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit hysteresis counters for the fetch stage.
// Optional define BTB_BYPASS_EN forwards a same-cycle update to a lookup of the same index.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] npc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    NH = 2'b00,
    NS = 2'b01,
    TS = 2'b10,
    TH = 2'b11
  } cnt_t;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  cnt_t             cnt_q    [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_match;
  logic             upd_write;
  logic [31:0]      new_target;
  cnt_t             new_cnt;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_target;
  cnt_t             rd_cnt;

  // The two low PC bits never select anything in a word-aligned BTB.
  logic unused_upd_low;
  assign unused_upd_low = ^upd_pc[1:0];

  // NS jumps straight to TH on a taken outcome; TS falls all the way to NH.
  function automatic cnt_t next_cnt(input cnt_t c, input logic t);
    cnt_t n;
    n = c;
    unique case (c)
      NH: n = t ? NS : NH;
      NS: n = t ? TH : NH;
      TS: n = t ? TH : NH;
      TH: n = t ? TH : TS;
      default: n = NH;
    endcase
    return n;
  endfunction

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Contents of the indexed entry after this update; a not-taken miss writes nothing.
  always_comb begin
    upd_match  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_write  = upd_en && (upd_match || upd_taken);
    new_target = upd_taken ? upd_target : target_q[upd_idx];
    new_cnt    = upd_match ? next_cnt(cnt_q[upd_idx], upd_taken) : TS;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= NH;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_write) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= new_target;
      cnt_q[upd_idx]    <= new_cnt;
    end
  end

  // Lookup read port, optionally overlaid with the in-flight update.
  always_comb begin
    rd_valid  = valid_q[if_idx];
    rd_tag    = tag_q[if_idx];
    rd_target = target_q[if_idx];
    rd_cnt    = cnt_q[if_idx];
`ifdef BTB_BYPASS_EN
    if (upd_en && (upd_idx == if_idx)) begin
      if (RST || flush) begin
        rd_valid = 1'b0;
      end else if (upd_write) begin
        rd_valid  = 1'b1;
        rd_tag    = upd_tag;
        rd_target = new_target;
        rd_cnt    = new_cnt;
      end
    end
`endif
  end

  assign pred_hit    = rd_valid && (rd_tag == if_tag);
  assign pred_taken  = pred_hit && rd_cnt[1];
  assign pred_target = pred_hit ? rd_target : 32'h0;
  assign npc         = pred_taken ? pred_target : (if_pc + 32'd4);

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized self-checking bench for branch_target_buffer against an entry-level model.
// Follows BTB_BYPASS_EN the same way the design does.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] npc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;

  always #5 CLK = ~CLK;

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .if_pc      (if_pc),
    .pred_hit   (pred_hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .npc        (npc),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush      (flush)
  );

  // Counter states held as plain numbers 0..3 (NH, NS, TS, TH); >= 2 predicts taken.
  typedef struct {
    bit          v;
    int unsigned tg;
    logic [31:0] tgt;
    int          c;
  } ent_t;

  ent_t m [ENTRIES];
  int   onTaken    [4] = '{1, 3, 3, 3};
  int   onNotTaken [4] = '{0, 0, 0, 2};
  int   assertCount = 0;
  int   failCount   = 0;

  function automatic int unsigned idxOf(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic ent_t afterUpdate(input ent_t e, input logic [31:0] pc,
                                       input bit t, input logic [31:0] tgt);
    ent_t r;
    r = e;
    if (e.v && e.tg == tagOf(pc)) begin
      r.c = t ? onTaken[e.c] : onNotTaken[e.c];
      if (t) r.tgt = tgt;
    end else if (t) begin
      r.v   = 1'b1;
      r.tg  = tagOf(pc);
      r.tgt = tgt;
      r.c   = 2;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < ENTRIES; i++) begin
      m[i].v = 1'b0; m[i].tg = 0; m[i].tgt = '0; m[i].c = 0;
    end
  endtask

  // One cycle: drive, check lookup against the model, then commit the model at the edge.
  task automatic applyStimulus(input bit r, input bit f, input bit e, input logic [31:0] upc,
                               input bit t, input logic [31:0] tgt, input logic [31:0] ipc,
                               input bit haveWant, input logic [31:0] wantNpc);
    ent_t        cur;
    bit          hit;
    bit          tk;
    logic [31:0] expTgt;
    logic [31:0] expNpc;
    @(negedge CLK);
    RST = r; flush = f; upd_en = e; upd_pc = upc; upd_taken = t; upd_target = tgt; if_pc = ipc;
    #1;
    cur = m[idxOf(ipc)];
`ifdef BTB_BYPASS_EN
    if (e && idxOf(upc) == idxOf(ipc)) begin
      if (r || f) cur.v = 1'b0;
      else        cur = afterUpdate(cur, upc, t, tgt);
    end
`endif
    hit    = cur.v && (cur.tg == tagOf(ipc));
    tk     = hit && (cur.c >= 2);
    expTgt = hit ? cur.tgt : 32'h0;
    expNpc = tk ? expTgt : ipc + 32'd4;
    checkOutput("pred_hit",    {31'b0, pred_hit},   {31'b0, hit});
    checkOutput("pred_taken",  {31'b0, pred_taken}, {31'b0, tk});
    checkOutput("pred_target", pred_target, expTgt);
    checkOutput("npc",         npc,         expNpc);
    if (haveWant) checkOutput("plan_npc", npc, wantNpc);
    @(posedge CLK);
    if (r)      clearModel();
    else if (f) for (int i = 0; i < ENTRIES; i++) m[i].v = 1'b0;
    else if (e) m[idxOf(upc)] = afterUpdate(m[idxOf(upc)], upc, t, tgt);
  endtask

  initial begin
    logic [31:0] bypassWant;
    RST = 1'b1; flush = 1'b0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; if_pc = 32'h40;
    clearModel();
    repeat (2) @(posedge CLK);

    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h44);
    applyStimulus(0, 0, 1, 32'h40, 1, 32'h100, 32'h44, 1, 32'h48);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h100);
    applyStimulus(0, 0, 1, 32'h40, 0, 32'h0,   32'h44, 1, 32'h48);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h44);
    applyStimulus(0, 0, 1, 32'h40, 1, 32'h100, 32'h44, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h44);
    applyStimulus(0, 0, 1, 32'h40, 1, 32'h100, 32'h44, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h100);
    applyStimulus(0, 0, 1, 32'h40, 0, 32'h0,   32'h44, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h100);
    // 0x80 aliases 0x40 in a 16-entry table and evicts it.
    applyStimulus(0, 0, 1, 32'h80, 1, 32'h200, 32'h44, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h44);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h80, 1, 32'h200);
    applyStimulus(0, 0, 1, 32'h40, 1, 32'h100, 32'h44, 0, 32'h0);
    applyStimulus(0, 1, 1, 32'h40, 1, 32'h100, 32'h44, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h44);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'hFFFFFFFC, 1, 32'h0);
    applyStimulus(0, 1, 0, 32'h0,  0, 32'h0,   32'h44, 0, 32'h0);
`ifdef BTB_BYPASS_EN
    bypassWant = 32'h100;
`else
    bypassWant = 32'h44;
`endif
    applyStimulus(0, 0, 1, 32'h40, 1, 32'h100, 32'h40, 1, bypassWant);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h100);
    applyStimulus(1, 0, 1, 32'h80, 1, 32'h200, 32'h44, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h80, 1, 32'h84);
    applyStimulus(0, 0, 0, 32'h0,  0, 32'h0,   32'h40, 1, 32'h44);

    // Small PC pool (4 tags x 16 indices) so hits, aliasing and training all recur.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] upc;
      logic [31:0] ipc;
      logic [31:0] tgt;
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      ipc = ($urandom_range(0, 31) == 0) ? 32'hFFFFFFFC
          : (($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      tgt = $urandom & 32'hFFFFFFFC;
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 1) == 1, upc, $urandom_range(0, 2) != 0, tgt, ipc,
                    0, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with per-entry 2-bit hysteresis counters, located in the fetch stage directly upstream of the PC mux. Each cycle it looks up the fetch PC and produces a predicted next PC: the cached target on a predicted-taken hit, otherwise PC+4. Branches resolved later in the pipeline write back through a single update port, which allocates entries and trains the counters.

## Interface
Parameters:
- ENTRIES, 16, number of entries; power of two, 4..256
- IDX_W, $clog2(ENTRIES), index width (derived)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset, synchronous, active-high
- if_pc  input  32  fetch PC (word aligned)
- pred_hit  output  1  valid entry with tag match for if_pc
- pred_taken  output  1  pred_hit && counter[1]
- pred_target  output  32  stored target on hit, else 0
- npc  output  32  pred_taken ? pred_target : if_pc+4
- upd_en  input  1  resolved-branch update strobe
- upd_pc  input  32  PC of resolved branch
- upd_taken  input  1  actual outcome
- upd_target  input  32  actual taken target
- flush  input  1  invalidate all entries

## Operation
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid (1), tag (30-IDX_W), target (32), cnt (2).
- Counter encoding: NH=00 (not-taken hard), NS=01 (not-taken soft), TS=10 (taken soft), TH=11 (taken hard). MSB = predict taken.
- Counter transitions (t = upd_taken):
  - NH: t→NS, !t→NH
  - NS: t→TH, !t→NH
  - TH: t→TH, !t→TS
  - TS: t→TH, !t→NH
- Update when upd_en and the indexed entry is valid with a matching tag: advance cnt; if upd_taken, also overwrite target with upd_target.
- Update when upd_en and the entry misses (invalid or tag mismatch):
  - upd_taken=1: allocate the entry (valid=1, tag, target=upd_target, cnt=TS), replacing any previous occupant.
  - upd_taken=0: no state change.
- flush=1: all valid bits clear at the next edge; counters, tags and targets are retained but unreachable.
- Priority at an edge: RST > flush > upd_en.
- npc arithmetic: if_pc+4 is 32-bit, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000).

## Timing
- Lookup is purely combinational from if_pc and registered state; 0-cycle latency.
- Update commits at the rising edge where upd_en=1. By default, a lookup in the same cycle sees the pre-update entry, and the result is visible from the next cycle.
- Reset: while RST=1 at an edge, all valid←0, cnt←NH, tag←0 and target←0 on that edge.
- After reset, outputs are pred_hit=0, pred_taken=0, pred_target=0 and npc=if_pc+4 until the first allocation.
- Reset mid-update: an upd_en coinciding with RST is discarded.
- No stall input: the block holds no in-flight state, and fetch stalls simply repeat if_pc.

## Configuration
- BTB_BYPASS_EN defined: when upd_en=1 and upd_pc index equals if_pc index in the same cycle, lookup outputs reflect the entry as it will be after the update, combinationally.
  - Includes allocation, counter advance and target change.
  - flush or RST in that cycle suppresses the bypass (outputs show a miss).
- BTB_BYPASS_EN undefined: no forwarding; same-cycle lookups see the old contents.

## Test plan
- Reset, then drive if_pc=0x00000040 → pred_hit=0, pred_taken=0, npc=0x00000044.
- Update upd_pc=0x40, taken=1, target=0x100; next cycle if_pc=0x40 → pred_hit=1, pred_taken=1 (TS), npc=0x100.
- From TS, apply not-taken → NH, npc=0x44. Then apply taken twice: first → NS, npc=0x44; second → TH, npc=0x100. Then apply not-taken → TS, npc=0x100.
- ENTRIES=16: allocate 0x40→0x100, then allocate 0x80 (same index)→0x200. Lookup 0x40 → miss, npc=0x44; lookup 0x80 → hit, npc=0x200.
- Allocate 0x40, then assert flush and upd_en (0x40, taken) in the same cycle → next-cycle lookup of 0x40 misses. Separately, if_pc=0xFFFFFFFC on a miss → npc=0x00000000.
- Same-cycle update and lookup of 0x40 (taken→0x100, empty BTB): with BTB_BYPASS_EN → npc=0x100 that cycle; without it → npc=0x44 that cycle and 0x100 the next.
